// File: rtl/clock_pkg.sv
// clock_pkg: shared limits, widths and state encoding for the time-of-day path.
// The setup stage reuses HOUR_MAX / MIN_MAX to bound what the user may enter.
// Contents:
//   TIME_W                     width of every hour/minute/second field
//   HOUR_MAX, MIN_MAX, SEC_MAX largest legal value of each field
//   state_t                    ST_UNSET (no time loaded yet) / ST_RUN
//   limit_or_zero()            replaces an out-of-range field with 0
package clock_pkg;

  localparam int TIME_W = 7;

  localparam logic [TIME_W-1:0] HOUR_MAX = 7'd23;
  localparam logic [TIME_W-1:0] MIN_MAX  = 7'd59;
  localparam logic [TIME_W-1:0] SEC_MAX  = 7'd59;

  typedef enum logic {
    ST_UNSET = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // An illegal entry becomes 0, so no out-of-range value ever reaches the outputs.
  function automatic logic [TIME_W-1:0] limit_or_zero(input logic [TIME_W-1:0] v,
                                                      input logic [TIME_W-1:0] max_v);
    return (v > max_v) ? '0 : v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler that turns CLK_FREQ clk cycles into one tick.
// Parameters:
//   CLK_FREQ  clk cycles per tick; the terminal count is CLK_FREQ-1
//   PRESC_W   counter width; 2**PRESC_W must exceed CLK_FREQ
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   enable      1 = count this cycle; 0 = hold, so no partial interval is lost
//   clear       restart the interval from 0; wins over enable
//   tick        combinational, high in the cycle the counter wraps
module tick_gen #(
  parameter int CLK_FREQ = 62_500_000,
  parameter int PRESC_W  = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESC_W-1:0] TERM = PRESC_W'(CLK_FREQ - 1);

  logic [PRESC_W-1:0] cnt;

  assign tick = enable & ~clear & (cnt == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == TERM) ? '0 : cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/clock_counter.sv
// clock_counter: time-of-day counter fed by the setup stage.
// Loads the user-set hour/minute on a rising edge of setup_ready, then counts
// seconds, minutes and hours from a 1 Hz tick produced by tick_gen.
// Parameters:
//   CLK_FREQ, PRESC_W  passed to the prescaler (clk cycles per second, width)
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   setup_hour, setup_minute   time entered upstream (out-of-range -> 0)
//   setup_ready                load request level; only its rising edge acts
//   run_en                     1 = time advances, 0 = frozen (prescaler held)
//   hour, minute, second       current time, always within 0..23 / 0..59 / 0..59
//   sec_tick                   one-cycle pulse with each new second value
//   day_rollover               one-cycle pulse when 23:59:59 becomes 00:00:00
//   time_valid                 0 until the first load, then 1
//   state_dbg                  current FSM state, for observation only
//   hour12, pm                 12-hour view of hour (only with HOUR12_EN)
// Build option: define HOUR12_EN to add the hour12/pm outputs.
//
// Handshake: setup_ready is a level held for about a second by the setup stage;
// there is no ready/acknowledge back. A load happens once per rising edge seen
// after reset release; setup_hour/setup_minute must be valid in that cycle.
module clock_counter
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 62_500_000,
  parameter int PRESC_W  = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TIME_W-1:0] setup_hour,
  input  logic [TIME_W-1:0] setup_minute,
  input  logic              setup_ready,
  input  logic              run_en,
  output logic [TIME_W-1:0] hour,
  output logic [TIME_W-1:0] minute,
  output logic [TIME_W-1:0] second,
  output logic              sec_tick,
  output logic              day_rollover,
  output logic              time_valid,
  output state_t            state_dbg
`ifdef HOUR12_EN
  ,
  output logic [TIME_W-1:0] hour12,
  output logic              pm
`endif
);

  state_t state, state_nx;
  logic   setup_ready_q;
  logic   edge_armed;
  logic   load;
  logic   count_en;
  logic   tick;

  // edge_armed is 0 only in the first cycle after reset release. That cycle
  // lets setup_ready_q catch up with a level that was already high across the
  // reset, so a held request cannot masquerade as a fresh rising edge.
  assign load     = edge_armed & setup_ready & ~setup_ready_q;
  // A load restarts the second, so any tick coinciding with it is discarded.
  assign count_en = (state == ST_RUN) & run_en & ~load;

  tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .PRESC_W  (PRESC_W)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (count_en),
    .clear  (load),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_UNSET;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: leave UNSET on the first load; RUN is only left through reset.
  always_comb begin
    state_nx = state;
    case (state)
      ST_UNSET: if (load) state_nx = ST_RUN;
      ST_RUN:   state_nx = ST_RUN;
      default:  state_nx = ST_UNSET;
    endcase
  end

  assign state_dbg = state;

  // Time fields and strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      setup_ready_q <= 1'b0;
      edge_armed    <= 1'b0;
      hour          <= '0;
      minute        <= '0;
      second        <= '0;
      sec_tick      <= 1'b0;
      day_rollover  <= 1'b0;
      time_valid    <= 1'b0;
    end else begin
      setup_ready_q <= setup_ready;
      edge_armed    <= 1'b1;
      sec_tick      <= 1'b0;
      day_rollover  <= 1'b0;
      if (load) begin
        hour       <= limit_or_zero(setup_hour, HOUR_MAX);
        minute     <= limit_or_zero(setup_minute, MIN_MAX);
        second     <= '0;
        time_valid <= 1'b1;
      end else if (tick) begin
        sec_tick     <= 1'b1;
        day_rollover <= (hour == HOUR_MAX) && (minute == MIN_MAX) && (second == SEC_MAX);
        if (second == SEC_MAX) begin
          second <= '0;
          if (minute == MIN_MAX) begin
            minute <= '0;
            hour   <= (hour == HOUR_MAX) ? '0 : hour + 7'd1;
          end else begin
            minute <= minute + 7'd1;
          end
        end else begin
          second <= second + 7'd1;
        end
      end
    end
  end

`ifdef HOUR12_EN
  // 0 -> 12 AM, 1..11 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
  always_comb begin
    hour12 = hour;
    pm     = (hour >= 7'd12);
    if (hour == 7'd0) begin
      hour12 = 7'd12;
    end else if (hour > 7'd12) begin
      hour12 = hour - 7'd12;
    end
  end
`endif

endmodule
